// File: rtl/noc_flit_pkg.sv
// -----------------------------------------------------------------------------
// noc_flit_pkg
// Shared flit definitions for the NoC exit-port collector.
//   FLIT_DW        : default flit width (32).
//   FT_MSB/FT_LSB  : bit positions of the 2-bit flit type field.
//   flit_type_e    : HEAD / BODY / TAIL / SINGLE encodings.
//   frame_state_e  : packet framing states IDLE / IN_PKT.
//   flit_type()    : extracts the type field from a FLIT_DW-wide flit.
// -----------------------------------------------------------------------------
package noc_flit_pkg;

  localparam int FLIT_DW = 32;

  localparam int FT_MSB = FLIT_DW - 1;
  localparam int FT_LSB = FLIT_DW - 2;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_e;

  function automatic flit_type_e flit_type(input logic [FLIT_DW-1:0] flit);
    return flit_type_e'(flit[FT_MSB:FT_LSB]);
  endfunction

endpackage : noc_flit_pkg

// File: rtl/flee_collector_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO used as the collector buffer.
// Pointers carry one extra wrap bit so full and empty are told apart by the
// pointer MSBs.
// Ports:
//   clk   in          rising-edge clock
//   rst   in          synchronous active-high reset (empties the FIFO)
//   push  in          write wdata (ignored when full)
//   pop   in          drop the head entry (ignored when empty)
//   wdata in  [DW]    write data
//   rdata out [DW]    head entry, valid whenever empty is low
//   full  out         DEPTH entries stored
//   empty out         no entries stored
//   count out [AW+1]  current occupancy
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push;
  logic          w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are meaningful, and this lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

  // Same index with different wrap bits means the writer is a lap ahead.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;
  assign rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule : sync_fifo

// File: rtl/flee_collector.sv
// -----------------------------------------------------------------------------
// flee_collector
// Receiver for a NoC exit ("flee") port. Accepts flits over valid/ready at a
// programmable duty cycle, buffers them in a FWFT FIFO for a downstream
// reader, tracks packet framing and counts packets and flits.
// Build option: define FLEE_COLLECTOR_CHECK_EN to compile in framing error
// detection and the sticky proto_err flag; otherwise proto_err is tied low.
// Ports:
//   clk           in         rising-edge clock
//   rst           in         synchronous active-high reset
//   data_i_flee   in  [DW]   flit from the exit port (type in [DW-1:DW-2])
//   valid_i_flee  in         flit valid
//   ready_o_flee  out        collector ready (window open and FIFO not full)
//   data_o        out [DW]   FIFO head (first-word-fall-through)
//   valid_o       out        FIFO not empty
//   ready_i       in         downstream pop
//   pkt_count     out [32]   completed packets (wraps)
//   flit_count    out [32]   accepted flits (wraps)
//   in_pkt        out        framing FSM is inside a packet
//   proto_err     out        sticky framing error
// -----------------------------------------------------------------------------
module flee_collector
  import noc_flit_pkg::*;
#(
  parameter int DW              = FLIT_DW,
  parameter int DEPTH           = 16,
  parameter int THROTTLE_PERIOD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_i_flee,
  input  logic          valid_i_flee,
  output logic          ready_o_flee,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [31:0]   pkt_count,
  output logic [31:0]   flit_count,
  output logic          in_pkt,
  output logic          proto_err
);

  localparam int TW  = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int PAD = FLIT_DW - 2;
  localparam logic [TW-1:0] T_LAST = TW'(THROTTLE_PERIOD - 1);

  logic [TW-1:0]      r_tcnt;
  frame_state_e       r_state;
  frame_state_e       w_next_state;
  logic [31:0]        r_pkt_count;
  logic [31:0]        r_flit_count;
  logic               w_gate;
  logic               w_accept;
  logic               w_pop;
  logic               w_pkt_inc;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CW-1:0]      w_fifo_count;
  logic [FLIT_DW-1:0] w_flit_aligned;
  flit_type_e         w_ftype;

  // ---------------------------------------------------------------------------
  // Acceptance window: open for one cycle at the end of every period.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || r_tcnt == T_LAST) r_tcnt <= '0;
    else                         r_tcnt <= r_tcnt + 1'b1;
  end

  assign w_gate = (r_tcnt == T_LAST);

  // Full comes from registered pointers, so ready never depends on
  // valid_i_flee or ready_i; a pop in the full cycle does not open a slot.
  assign ready_o_flee = ~rst & w_gate & ~w_fifo_full;
  assign w_accept     = valid_i_flee & ready_o_flee;
  assign w_pop        = ready_i & (w_fifo_count != '0);

  // Move the type field into the package's flit layout so the shared
  // decoder works for any DW.
  assign w_flit_aligned = {data_i_flee[DW-1 -: 2], {PAD{1'b0}}};
  assign w_ftype        = flit_type(w_flit_aligned);

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_pkt_inc    = 1'b0;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          case (w_ftype)
            HEAD:    w_next_state = IN_PKT;
            SINGLE:  w_pkt_inc    = 1'b1;
            default: ;
          endcase
        end
        IN_PKT: begin
          // HEAD restarts the packet and BODY continues it: both stay here.
          case (w_ftype)
            TAIL, SINGLE: begin
              w_pkt_inc    = 1'b1;
              w_next_state = IDLE;
            end
            default: ;
          endcase
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  assign in_pkt = (r_state == IN_PKT);

  // ---------------------------------------------------------------------------
  // Counters (free-running, wrap modulo 2^32)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_count  <= '0;
      r_flit_count <= '0;
    end else begin
      if (w_accept)  r_flit_count <= r_flit_count + 32'd1;
      if (w_pkt_inc) r_pkt_count  <= r_pkt_count + 32'd1;
    end
  end

  assign pkt_count  = r_pkt_count;
  assign flit_count = r_flit_count;

  // ---------------------------------------------------------------------------
  // Framing error detection
  // ---------------------------------------------------------------------------
`ifdef FLEE_COLLECTOR_CHECK_EN
  logic r_proto_err;
  logic w_illegal;

  // BODY/TAIL with no open packet, or HEAD/SINGLE while one is open.
  assign w_illegal = w_accept &
                     (((r_state == IDLE)   & ((w_ftype == BODY) | (w_ftype == TAIL))) |
                      ((r_state == IN_PKT) & ((w_ftype == HEAD) | (w_ftype == SINGLE))));

  always_ff @(posedge clk) begin
    if (rst)            r_proto_err <= 1'b0;
    else if (w_illegal) r_proto_err <= 1'b1;
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Flit buffer
  // ---------------------------------------------------------------------------
  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept),
    .pop   (w_pop),
    .wdata (data_i_flee),
    .rdata (data_o),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign valid_o = ~w_fifo_empty;

endmodule : flee_collector

// File: tb/tb_flee_collector.sv
// -----------------------------------------------------------------------------
// tb_flee_collector
// Self-checking bench for flee_collector. Two instances: u_dut_a (period 1)
// for framing, FIFO full, reset and pointer-wrap traffic, and u_dut_b
// (period 16) for the acceptance window. Accepted flits are queued as
// expected output; independent monitors pop and compare whenever an instance
// presents a flit that is being read. Honours FLEE_COLLECTOR_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_flee_collector;
  import noc_flit_pkg::*;

  localparam int DW    = FLIT_DW;
  localparam int DEPTH = 16;

`ifdef FLEE_COLLECTOR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals (period 1)
  logic          rst_a   = 1'b1;
  logic [DW-1:0] a_data  = '0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [DW-1:0] a_dout;
  logic          a_vout;
  logic          a_rdy_i = 1'b1;
  logic [31:0]   a_pkt, a_flit;
  logic          a_in_pkt, a_err;

  // Instance B signals (period 16)
  logic          rst_b   = 1'b1;
  logic [DW-1:0] b_data  = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [DW-1:0] b_dout;
  logic          b_vout;
  logic          b_rdy_i = 1'b1;
  logic [31:0]   b_pkt, b_flit;
  logic          b_in_pkt, b_err;

  flee_collector #(.DW(DW), .DEPTH(DEPTH), .THROTTLE_PERIOD(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .data_i_flee(a_data), .valid_i_flee(a_valid),
    .ready_o_flee(a_ready), .data_o(a_dout), .valid_o(a_vout), .ready_i(a_rdy_i),
    .pkt_count(a_pkt), .flit_count(a_flit), .in_pkt(a_in_pkt), .proto_err(a_err)
  );

  flee_collector #(.DW(DW), .DEPTH(DEPTH), .THROTTLE_PERIOD(16)) u_dut_b (
    .clk(clk), .rst(rst_b), .data_i_flee(b_data), .valid_i_flee(b_valid),
    .ready_o_flee(b_ready), .data_o(b_dout), .valid_o(b_vout), .ready_i(b_rdy_i),
    .pkt_count(b_pkt), .flit_count(b_flit), .in_pkt(b_in_pkt), .proto_err(b_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input flit_type_e t, input logic [DW-3:0] pl);
    return {t, pl};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard for instance A: queue of expected flits plus a framing model
  // (used for the long random run).
  // ---------------------------------------------------------------------------
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  frame_state_e  m_state = IDLE;
  logic [31:0]   m_pkt   = '0;
  logic [31:0]   m_flit  = '0;
  logic          m_err   = 1'b0;

  task automatic model_accept(input logic [DW-1:0] f);
    flit_type_e t;
    t = flit_type_e'(f[DW-1:DW-2]);
    m_flit++;
    if (m_state == IDLE) begin
      if (t == HEAD)        m_state = IN_PKT;
      else if (t == SINGLE) m_pkt++;
      else                  m_err = 1'b1;
    end else begin
      if (t == TAIL) begin
        m_pkt++; m_state = IDLE;
      end else if (t == HEAD) begin
        m_err = 1'b1;
      end else if (t == SINGLE) begin
        m_err = 1'b1; m_pkt++; m_state = IDLE;
      end
    end
  endtask

  // Handshake is sampled mid-cycle and committed on the following edge.
  bit            a_hs;
  logic [DW-1:0] a_hs_data;
  always @(negedge clk) begin
    a_hs      = a_valid && a_ready;
    a_hs_data = a_data;
  end

  always @(posedge clk) begin
    if (rst_a) begin
      qa.delete();
      m_state = IDLE; m_pkt = '0; m_flit = '0; m_err = 1'b0;
    end else if (a_hs) begin
      qa.push_back(a_hs_data);
      model_accept(a_hs_data);
    end
  end

  // Output monitor A
  always @(negedge clk) begin
    if (!rst_a) begin
      check("a_valid_o_vs_occupancy", a_vout, qa.size() != 0);
      check("a_occupancy_le_depth", qa.size() <= DEPTH, 1'b1);
      if (a_vout && a_rdy_i) begin
        if (qa.size() == 0) check("a_pop_with_no_expected", a_vout, 1'b0);
        else check("a_data_o", a_dout, qa.pop_front());
      end
    end
  end

  // Output monitor B
  always @(negedge clk) begin
    if (!rst_b && b_vout && b_rdy_i) begin
      if (qb.size() == 0) check("b_pop_with_no_expected", b_vout, 1'b0);
      else check("b_data_o", b_dout, qb.pop_front());
    end
  end

  // Random downstream back-pressure for the wrap run
  bit rand_rdy = 1'b0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      a_rdy_i = 1'($urandom_range(0, 1));
    end
  end

  // Advance to 1 time unit after the n-th next rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one flit to A; returns 1 unit after the accepting edge.
  task automatic send_a(input logic [DW-1:0] f);
    int w;
    a_data  = f;
    a_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!a_ready && w < 300);
    if (!a_ready) check("a_accept_timeout", a_ready, 1'b1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic drain_a(input string name);
    for (int w = 0; w < 200 && qa.size() != 0; w++) step(1);
    check(name, qa.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run time %0t exceeded limit 1000000", $time);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] f;
    logic [DW-3:0] pl;
    int sent;
    bit acc;

    // ---------------- Reset state ----------------
    step(3);
    @(negedge clk);
    check("rst_a_ready_o", a_ready, 1'b0);
    check("rst_a_valid_o", a_vout, 1'b0);
    check("rst_a_pkt_count", a_pkt, 32'd0);
    check("rst_a_flit_count", a_flit, 32'd0);
    check("rst_a_in_pkt", a_in_pkt, 1'b0);
    check("rst_a_proto_err", a_err, 1'b0);
    check("rst_b_ready_o", b_ready, 1'b0);
    check("rst_b_valid_o", b_vout, 1'b0);
    step(1);

    // ---------------- Throttling (P=16) ----------------
    rst_b   = 1'b0;
    b_valid = 1'b1;
    sent    = 0;
    b_data  = mk(SINGLE, 30'h0);
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      check($sformatf("b_ready_cycle%0d", c), b_ready, (c % 16) == 15);
      acc = b_ready;
      if (acc) qb.push_back(b_data);
      step(1);
      if (acc) begin
        sent++;
        b_data = mk(SINGLE, 30'(sent));
      end
    end
    b_valid = 1'b0;
    step(3);
    @(negedge clk);
    check("b_pkt_count", b_pkt, 32'd10);
    check("b_flit_count", b_flit, 32'd10);
    check("b_proto_err", b_err, 1'b0);
    check("b_in_pkt", b_in_pkt, 1'b0);
    check("b_drained", qb.size(), 0);
    step(1);

    // ---------------- Single packet (P=1) ----------------
    rst_a = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      f = mk((i == 0) ? HEAD : (i == 4) ? TAIL : BODY, 30'(32'hA0 + i));
      send_a(f);
      @(negedge clk);
      check("t1_latency_valid", a_vout, 1'b1);
      check("t1_latency_data", a_dout, f);
      if (i == 0) check("t1_in_pkt_after_head", a_in_pkt, 1'b1);
      step(1);
    end
    step(1);
    @(negedge clk);
    check("t1_pkt_count", a_pkt, 32'd1);
    check("t1_flit_count", a_flit, 32'd5);
    check("t1_proto_err", a_err, 1'b0);
    check("t1_in_pkt", a_in_pkt, 1'b0);
    step(1);

    // ---------------- FIFO full ----------------
    a_rdy_i = 1'b0;
    for (int i = 0; i < 16; i++) send_a(mk(SINGLE, 30'(32'h100 + i)));
    a_data  = mk(SINGLE, 30'h110);
    a_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_full_ready", a_ready, 1'b0);
    end
    step(1);
    a_rdy_i = 1'b1;
    @(negedge clk);
    check("t3_pop_cycle_ready", a_ready, 1'b0);
    step(1);
    a_rdy_i = 1'b0;
    @(negedge clk);
    check("t3_resume_ready", a_ready, 1'b1);
    step(1);
    a_data = mk(SINGLE, 30'h111);
    @(negedge clk);
    check("t3_full_again_ready", a_ready, 1'b0);
    step(1);
    a_valid = 1'b0;
    a_rdy_i = 1'b1;
    for (int i = 17; i < 20; i++) send_a(mk(SINGLE, 30'(32'h100 + i)));
    drain_a("t3_drained");
    @(negedge clk);
    check("t3_flit_count", a_flit, 32'd25);
    check("t3_pkt_count", a_pkt, 32'd21);
    step(1);

    // ---------------- Framing errors ----------------
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    step(1);
    send_a(mk(BODY, 30'h200));
    @(negedge clk);
    check("t4_err_after_body", a_err, EXP_ERR);
    check("t4_pkt_after_body", a_pkt, 32'd0);
    check("t4_in_pkt_after_body", a_in_pkt, 1'b0);
    step(1);
    send_a(mk(HEAD, 30'h201));
    send_a(mk(HEAD, 30'h202));
    @(negedge clk);
    check("t4_in_pkt_after_2head", a_in_pkt, 1'b1);
    step(1);
    send_a(mk(TAIL, 30'h203));
    step(1);
    @(negedge clk);
    check("t4_pkt_count", a_pkt, 32'd1);
    check("t4_flit_count", a_flit, 32'd4);
    check("t4_err_sticky", a_err, EXP_ERR);
    check("t4_in_pkt_end", a_in_pkt, 1'b0);
    step(1);

    // ---------------- Reset mid-packet ----------------
    a_rdy_i = 1'b0;
    send_a(mk(HEAD, 30'h300));
    send_a(mk(BODY, 30'h301));
    @(negedge clk);
    check("t5_in_pkt_before_rst", a_in_pkt, 1'b1);
    check("t5_valid_before_rst", a_vout, 1'b1);
    step(1);
    rst_a = 1'b1;
    @(negedge clk);
    check("t5_ready_in_rst", a_ready, 1'b0);
    step(1);
    rst_a = 1'b0;
    @(negedge clk);
    check("t5_valid_o", a_vout, 1'b0);
    check("t5_pkt_count", a_pkt, 32'd0);
    check("t5_flit_count", a_flit, 32'd0);
    check("t5_in_pkt", a_in_pkt, 1'b0);
    check("t5_proto_err", a_err, 1'b0);
    step(1);
    a_rdy_i = 1'b1;
    send_a(mk(SINGLE, 30'h310));
    step(1);
    @(negedge clk);
    check("t5_pkt_after_single", a_pkt, 32'd1);
    check("t5_flit_after_single", a_flit, 32'd1);
    step(1);

    // ---------------- Pointer wrap: random legal packets ----------------
    rand_rdy = 1'b1;
    sent = 0;
    while (sent < 1000) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        pl = 30'($urandom());
        if (len == 1)          f = mk(SINGLE, pl);
        else if (k == 0)       f = mk(HEAD, pl);
        else if (k == len - 1) f = mk(TAIL, pl);
        else                   f = mk(BODY, pl);
        send_a(f);
        sent++;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    a_rdy_i = 1'b1;
    drain_a("t6_drained");
    @(negedge clk);
    check("t6_flit_count", a_flit, m_flit);
    check("t6_pkt_count", a_pkt, m_pkt);
    check("t6_proto_err", a_err, 1'b0);
    check("t6_in_pkt", a_in_pkt, 1'b0);
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_flee_collector
